freq_meter_scan: RTL and testbench

Second-generation frequency meter. It counts rising edges of an asynchronous input over a gapless, parametrised gate window and publishes the per-window count with a valid strobe and an overflow flag. A sequential binary-to-BCD converter feeds a time-multiplexed N-digit seven-segment driver with leading-zero blanking. It sits between the board input pin and the display pins, and replaces the fixed 8-digit, dead-time-gated counter.

---
 rtl/freq_meter_pkg.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 93 +++++++++
 rtl/freq_meter_scan.sv | 155 +++++++++++++++
 tb/tb_freq_meter_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the frequency meter.
//   SEG_*          active-low segment patterns ([6:0]=g..a, [7]=dp)
//   conv_state_t   state encoding of the sequential BCD converter
//   bcd_to_seg     BCD digit to segment pattern (non-decimal -> blank)
//   pow10_minus1   largest value representable in n decimal digits
package freq_meter_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  typedef enum logic {
    CONV_IDLE,
    CONV_BUSY
  } conv_state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10_minus1(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter.
//   clock, reset_n  clock and asynchronous active-low reset
//   start           load bin and begin a conversion (ignored while busy)
//   bin             binary value to convert
//   done            one-cycle pulse, COUNT_W+1 cycles after start
//   bcd             NUM_DIGITS packed BCD digits, digit 0 in [3:0]
//   too_big         bin exceeds the NUM_DIGITS decimal range
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [COUNT_W-1:0]      bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    too_big
);

  localparam int unsigned CW = $clog2(COUNT_W + 1);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  conv_state_t      state, state_nx;
  logic [COUNT_W-1:0] shift_q;
  logic [DW-1:0]      acc_q, acc_adj, acc_nx;
  logic [CW-1:0]      bit_cnt;
  logic               big_q;
  logic               last_bit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CONV_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    last_bit = (bit_cnt == CW'(COUNT_W - 1));
    case (state)
      CONV_IDLE: if (start)    state_nx = CONV_BUSY;
      CONV_BUSY: if (last_bit) state_nx = CONV_IDLE;
      default:                 state_nx = CONV_IDLE;
    endcase
  end

  // Accumulator is only NUM_DIGITS wide: carries out of the top digit are
  // dropped, so it holds bin mod 10^NUM_DIGITS and too_big flags the rest.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_nx = {acc_adj[DW-2:0], shift_q[COUNT_W-1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      bit_cnt <= '0;
      big_q   <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      too_big <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CONV_IDLE: begin
          if (start) begin
            shift_q <= bin;
            acc_q   <= '0;
            bit_cnt <= '0;
            big_q   <= (64'(bin) > pow10_minus1(NUM_DIGITS));
          end
        end
        CONV_BUSY: begin
          shift_q <= shift_q << 1;
          acc_q   <= acc_nx;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            done    <= 1'b1;
            bcd     <= acc_nx;
            too_big <= big_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/freq_meter_scan.sv
// Gapless-window frequency meter with multiplexed seven-segment output.
//   clock, reset_n  system clock, asynchronous active-low reset
//   signal_in       measured signal (asynchronous)
//   hold            1 = keep the published result and display frozen
//   freq_out        rising edges counted in the last published window
//   freq_valid      one-cycle pulse when freq_out updates
//   overflow        last published window saturated
//   digit           active-low one-hot digit enable
//   segment         active-low segments, [7]=dp (always off)
module freq_meter_scan
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  signal_in,
  input  logic                  hold,
  output logic [COUNT_W-1:0]    freq_out,
  output logic                  freq_valid,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit,
  output logic [7:0]            segment
);

  localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Input synchroniser and rising-edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sig_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Gate timer and saturating edge counter
  logic [GW-1:0]      gate_q;
  logic [COUNT_W-1:0] edge_cnt, cap_cnt;
  logic               ovf_acc, cap_ovf;
  logic               window_end, at_max;

  assign window_end = (gate_q == GW'(GATE_CYCLES - 1));
  assign at_max     = (edge_cnt == CNT_MAX);
  assign cap_cnt    = (sig_rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign cap_ovf    = ovf_acc | (sig_rise & at_max);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_q     <= '0;
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (window_end) begin
        gate_q   <= '0;
        edge_cnt <= '0;
        ovf_acc  <= 1'b0;
        if (!hold) begin
          freq_out   <= cap_cnt;
          overflow   <= cap_ovf;
          freq_valid <= 1'b1;
        end
      end else begin
        gate_q   <= gate_q + 1'b1;
        edge_cnt <= cap_cnt;
        ovf_acc  <= cap_ovf;
      end
    end
  end

  // BCD conversion and display register
  logic                    conv_done, conv_too_big;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    disp_err;

  bin2bcd_seq #(
    .COUNT_W    (COUNT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (freq_valid),
    .bin     (freq_out),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .too_big (conv_too_big)
  );

  // Overflow is captured alongside the digits so the shown value is one snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_bcd <= '0;
      disp_err <= 1'b0;
    end else if (conv_done) begin
      disp_bcd <= conv_bcd;
      disp_err <= conv_too_big | overflow;
    end
  end

  // Scanner: digit and segment reload together only on a scan step
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx_q, idx_nx, msd;
  logic          scan_wrap;
  logic [7:0]    seg_nx;

  assign scan_wrap = (scan_cnt == SW'(SCAN_CYCLES - 1));
  assign idx_nx    = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    end
    if (disp_err)          seg_nx = SEG_DASH;
    else if (idx_nx > msd) seg_nx = SEG_BLANK;
    else                   seg_nx = bcd_to_seg(disp_bcd[{idx_nx, 2'b00} +: 4]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx_q    <= '0;
      digit    <= ~NUM_DIGITS'(1);
      segment  <= SEG_ZERO;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx_q    <= idx_nx;
      digit    <= ~(NUM_DIGITS'(1) << idx_nx);
      segment  <= seg_nx;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_meter_scan.sv
// Directed bench for freq_meter_scan (GATE=1000, COUNT_W=8, 8 digits, SCAN=4).
// k counts clock edges since reset release; timer = k mod 1000 and the
// scan index during interval k is (k/4) mod 8.
module tb_freq_meter_scan;

  localparam int unsigned GATE = 1000;
  localparam int unsigned CW   = 8;
  localparam int unsigned ND   = 8;
  localparam int unsigned SCAN = 4;

  localparam logic [63:0] SEGS_100  = 64'hFFFF_FFFF_FFF9_C0C0;
  localparam logic [63:0] SEGS_0    = 64'hFFFF_FFFF_FFFF_FFC0;
  localparam logic [63:0] SEGS_1    = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] SEGS_DASH = 64'hBFBF_BFBF_BFBF_BFBF;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          signal_in;
  logic          hold;
  logic [CW-1:0] freq_out;
  logic          freq_valid;
  logic          overflow;
  logic [ND-1:0] digit;
  logic [7:0]    segment;

  typedef enum {M_LOW, M_P10, M_P2, M_PU997, M_PU998} mode_t;
  mode_t mode;

  int unsigned k;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned vcnt     = 0;
  int unsigned vsnap;

  always #5 clock = ~clock;

  freq_meter_scan #(
    .GATE_CYCLES (GATE),
    .COUNT_W     (CW),
    .NUM_DIGITS  (ND),
    .SCAN_CYCLES (SCAN),
    .SYNC_STAGES (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .signal_in  (signal_in),
    .hold       (hold),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .digit      (digit),
    .segment    (segment)
  );

  always @(negedge clock) begin
    if (reset_n === 1'b1 && freq_valid === 1'b1) vcnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
  endtask

  // Periodic modes are forced low in the last two cycles of a window so
  // every window boundary is clean.
  function automatic logic sig_val(input int unsigned kk);
    int unsigned w;
    w = kk % GATE;
    case (mode)
      M_P10:   return (w >= 998) ? 1'b0 : ((kk % 10) < 5);
      M_P2:    return (w >= 998) ? 1'b0 : ((kk % 2) == 0);
      M_PU997: return (w == 997);
      M_PU998: return (w == 998);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    signal_in = sig_val(k);
    @(posedge clock);
    k++;
    @(negedge clock);
  endtask

  task automatic run_to(input int unsigned target);
    while (k < target) tick();
  endtask

  task automatic check_close(input string tag, input logic [7:0] f, input logic o, input logic v);
    check({tag, "_valid"}, 32'(freq_valid), 32'(v));
    check({tag, "_freq"},  32'(freq_out),   32'(f));
    check({tag, "_ovf"},   32'(overflow),   32'(o));
  endtask

  task automatic check_display(input string tag, input logic [63:0] segs);
    int unsigned i;
    logic [7:0] dexp;
    for (int n = 0; n < 32; n++) begin
      i = (k / SCAN) % ND;
      dexp = ~(8'd1 << i);
      check(tag, {16'h0, digit, segment}, {16'h0, dexp, segs[8*i +: 8]});
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_freq"},  32'(freq_out),   32'h0);
    check({tag, "_valid"}, 32'(freq_valid), 32'h0);
    check({tag, "_ovf"},   32'(overflow),   32'h0);
    check({tag, "_digit"}, 32'(digit),      32'hFE);
    check({tag, "_seg"},   32'(segment),    32'hC0);
  endtask

  initial begin
    reset_n   = 1'b0;
    hold      = 1'b0;
    signal_in = 1'b0;
    mode      = M_LOW;
    k         = 0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;

    // 10-cycle square wave
    mode = M_P10;
    run_to(1000);
    check_close("p10_w1", 8'd100, 1'b0, 1'b1);
    tick();
    check("p10_pulse_len", 32'(freq_valid), 32'h0);
    run_to(1050);
    check_display("disp_100", SEGS_100);
    run_to(2000);
    mode = M_LOW;
    check_close("p10_w2", 8'd100, 1'b0, 1'b1);
    tick();
    check("pulse_count", vcnt, 32'd2);

    // input held low
    run_to(3000);
    mode = M_P2;
    check_close("zero", 8'd0, 1'b0, 1'b1);
    run_to(3050);
    check_display("disp_0", SEGS_0);

    // saturation, then recovery
    run_to(4000);
    mode = M_P10;
    check_close("sat", 8'd255, 1'b1, 1'b1);
    run_to(4050);
    check_display("disp_dash", SEGS_DASH);
    run_to(5000);
    mode = M_P2;
    hold = 1'b1;
    check_close("recover", 8'd100, 1'b0, 1'b1);
    run_to(5050);
    check_display("disp_100b", SEGS_100);
    vsnap = vcnt;

    // hold across two closes
    run_to(6000);
    check_close("hold1", 8'd100, 1'b0, 1'b0);
    run_to(6050);
    check_display("disp_hold", SEGS_100);
    run_to(7000);
    hold = 1'b0;
    check_close("hold2", 8'd100, 1'b0, 1'b0);
    tick();
    check("hold_pulses", vcnt, vsnap);
    run_to(8000);
    mode = M_PU997;
    check_close("unhold", 8'd255, 1'b1, 1'b1);

    // window boundary edges
    run_to(9000);
    mode = M_PU998;
    check_close("edge_at_999", 8'd1, 1'b0, 1'b1);
    run_to(10000);
    mode = M_LOW;
    check_close("edge_next_a", 8'd0, 1'b0, 1'b1);
    run_to(11000);
    mode = M_P10;
    check_close("edge_next_b", 8'd1, 1'b0, 1'b1);
    run_to(11050);
    check_display("disp_1", SEGS_1);

    // asynchronous reset mid-window
    run_to(11500);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    signal_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    vsnap = vcnt;
    check_display("disp_rst", SEGS_0);
    run_to(999);
    check("rst_no_early_valid", 32'(freq_valid), 32'h0);
    check("rst_freq_hold", 32'(freq_out), 32'h0);
    check("rst_pulses", vcnt, vsnap);
    run_to(1000);
    check_close("post_rst", 8'd100, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
